dit_frame_ctrl: RTL and testbench
=================================

Name: dit_frame_ctrl

Overview:
- Frame sequencer for the 8-point radix-2 DIT FFT core (`dit`).
- Accepts a serial stream of 3-bit complex samples over a valid/ready handshake and assembles them into an 8-sample frame on the core's parallel inputs.
- Holds the frame stable for the core's compute latency, then drives the core's `sel` input 0..7 and streams the 8-bit complex results out over a valid/ready handshake.
- Sits between the sample source and downstream consumer; the core is instantiated beside it, not inside it.

Parameters:
- DW_IN, 3, input sample width per real/imag part (matches core xr/xi).
- DW_OUT, 8, result width per part (matches core yr/yi).
- CORE_LAT, 2, cycles from stable frame to valid core outputs; range 1..15.
- SEL_LAT, 1, cycles from a `fft_sel` change to valid fft_yr/fft_yi; range 0..3.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  controller accepts sample
- in_re  in  DW_IN  sample real part
- in_im  in  DW_IN  sample imag part
- fft_xr  out  8*DW_IN  frame real parts; sample k at bits [k*DW_IN +: DW_IN]
- fft_xi  out  8*DW_IN  frame imag parts; same packing
- fft_sel  out  3  core output select
- fft_yr  in  DW_OUT  core selected real result
- fft_yi  in  DW_OUT  core selected imag result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_re  out  DW_OUT  result real
- out_im  out  DW_OUT  result imag
- out_idx  out  3  frequency bin of the current result
- out_last  out  1  high with bin 7
- busy  out  1  high in any state other than LOAD with count 0

Behaviour:
- Reset (rst low, asynchronous): state=LOAD, load count=0, frame registers=0, fft_sel=0, out_valid=0, out_re/out_im/out_idx=0, out_last=0, in_ready=0. in_ready rises on the first clock after deassertion.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, the sample is written to slot cnt and cnt increments.
  - Acceptance of the 8th sample (cnt=7) moves to WAIT with the wait counter = CORE_LAT-1; cnt wraps to 0.
- WAIT:
  - in_ready=0; frame registers frozen.
  - Decrement each cycle; at 0 go to SEL with k=0.
- SEL:
  - fft_sel=k; settle counter = SEL_LAT.
  - When the counter reaches 0, register fft_yr/fft_yi into out_re/out_im, set out_idx=k, out_last=(k==7), out_valid=1, then go to DRAIN.
  - With SEL_LAT=0, capture happens in the same cycle SEL is entered.
- DRAIN:
  - out_valid held with stable data until out_ready.
  - On out_valid&&out_ready: out_valid=0 next cycle.
  - If k=7, go to LOAD; otherwise k++ and return to SEL.
  - Back-to-back: no bubble is required; one bubble cycle per bin is permitted.
- fft_sel changes only on SEL entry; stable throughout SEL and DRAIN.
- Frame registers are never written outside LOAD, so core inputs are stable from WAIT entry through the last handshake.
- No arithmetic is performed; widths pass straight through, with no sign extension or truncation.
- in_valid while in_ready=0 is ignored; the sample is not lost, and the source holds it per the handshake.
- out_ready asserted with out_valid=0 has no effect.
- Reset mid-frame discards the partial frame and any pending result.

Optional Feature:
- Macro DIT_FRAME_CTRL_BITREV_LOAD_EN.
- Defined: the sample with arrival index n is written to slot bitrev3(n) (0,4,2,6,1,5,3,7), i.e. the bit-reversed input ordering for a core that expects it. Outputs remain in natural order 0..7.
- Undefined: sample n is written to slot n.

Decomposition:
- Shared package dit_pkg holds:
  - N_POINTS=8 and LOG2N=3;
  - the default DW_IN/DW_OUT;
  - the state encoding enum {LOAD, WAIT, SEL, DRAIN};
  - a bitrev3 function.
- One natural sub-module, dit_frame_buf: the 8-slot frame register file with write-enable and address, plus packed outputs.
- The FSM and counters stay in the top.

Test Plan:
- Frame {1,0,1,0,1,0,1,0} (imag 0), out_ready=1: results are bin0=(4,0), bin4=(4,0), all other bins (0,0); out_last only on bin 7; in_ready stays 0 from the 8th accept until after the bin-7 handshake.
- Impulse {1,0,0,0,0,0,0,0}: all 8 bins are (1,0); out_idx runs 0..7 in order.
- Backpressure: out_ready low for 5 cycles on bin 3: out_re/out_im/out_idx/fft_sel stay stable; no bin is skipped or duplicated.
- Gapped input (in_valid toggling every other cycle): the frame completes only after 8 accepts; WAIT lasts exactly CORE_LAT cycles, checked with CORE_LAT=2 and CORE_LAT=4.
- rst pulsed low during DRAIN at bin 5: out_valid drops immediately (asynchronous); the next frame {4,0,0,0,4,0,0,0} yields bin0=(8,0), bin2=(8,0), bin4=(8,0), bin6=(8,0), odd bins (0,0).
- With DIT_FRAME_CTRL_BITREV_LOAD_EN: arrival sequence 0..7 lands in slots 0,4,2,6,1,5,3,7, checked on fft_xr.

Source files
------------

// File: rtl/dit_pkg.sv
// Shared definitions for the 8-point DIT FFT frame sequencer.
// Holds frame geometry, default widths, FSM encoding and bit reversal.
package dit_pkg;

    localparam int N_POINTS   = 8;
    localparam int LOG2N      = 3;
    localparam int DW_IN_DEF  = 3;
    localparam int DW_OUT_DEF = 8;

    typedef enum logic [1:0] {
        LOAD,
        WAIT,
        SEL,
        DRAIN
    } state_t;

    function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] n);
        return {n[0], n[1], n[2]};
    endfunction

endpackage

// File: rtl/dit_frame_buf.sv
// 8-slot frame register file feeding the FFT core's parallel inputs.
// Slot k is presented at bits [k*DW +: DW] of the packed outputs.
module dit_frame_buf
    import dit_pkg::*;
#(
    parameter int DW = DW_IN_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [LOG2N-1:0]       addr,
    input  logic [DW-1:0]          wr_re,
    input  logic [DW-1:0]          wr_im,
    output logic [N_POINTS*DW-1:0] xr,
    output logic [N_POINTS*DW-1:0] xi
);

    logic [N_POINTS-1:0][DW-1:0] re_q;
    logic [N_POINTS-1:0][DW-1:0] im_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            re_q <= '0;
            im_q <= '0;
        end else if (we) begin
            re_q[addr] <= wr_re;
            im_q[addr] <= wr_im;
        end
    end

    assign xr = re_q;
    assign xi = im_q;

endmodule

// File: rtl/dit_frame_ctrl.sv
// Frame sequencer for the 8-point DIT FFT core: load 8 samples, wait, stream bins.
// Define DIT_FRAME_CTRL_BITREV_LOAD_EN to store arrivals in bit-reversed slots.
module dit_frame_ctrl
    import dit_pkg::*;
#(
    parameter int DW_IN    = DW_IN_DEF,
    parameter int DW_OUT   = DW_OUT_DEF,
    parameter int CORE_LAT = 2,
    parameter int SEL_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DW_IN-1:0]          in_re,
    input  logic [DW_IN-1:0]          in_im,
    output logic [N_POINTS*DW_IN-1:0] fft_xr,
    output logic [N_POINTS*DW_IN-1:0] fft_xi,
    output logic [LOG2N-1:0]          fft_sel,
    input  logic [DW_OUT-1:0]         fft_yr,
    input  logic [DW_OUT-1:0]         fft_yi,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DW_OUT-1:0]         out_re,
    output logic [DW_OUT-1:0]         out_im,
    output logic [LOG2N-1:0]          out_idx,
    output logic                      out_last,
    output logic                      busy
);

    localparam logic [3:0] WCNT_INIT = 4'(CORE_LAT - 1);
    localparam logic [1:0] SCNT_INIT = 2'(SEL_LAT);

    state_t            state, state_d;
    logic [LOG2N-1:0]  cnt, cnt_d;
    logic [3:0]        wcnt, wcnt_d;
    logic [1:0]        scnt, scnt_d;
    logic [LOG2N-1:0]  sel_d;
    logic              valid_d;
    logic              ready_d;
    logic [DW_OUT-1:0] re_d, im_d;
    logic [LOG2N-1:0]  idx_d;
    logic              last_d;
    logic              we;
    logic [LOG2N-1:0]  wr_addr;

`ifdef DIT_FRAME_CTRL_BITREV_LOAD_EN
    assign wr_addr = bitrev3(cnt);
`else
    assign wr_addr = cnt;
`endif

    dit_frame_buf #(
        .DW(DW_IN)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .addr  (wr_addr),
        .wr_re (in_re),
        .wr_im (in_im),
        .xr    (fft_xr),
        .xi    (fft_xi)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOAD;
            cnt       <= '0;
            wcnt      <= '0;
            scnt      <= '0;
            fft_sel   <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            wcnt      <= wcnt_d;
            scnt      <= scnt_d;
            fft_sel   <= sel_d;
            out_valid <= valid_d;
            out_re    <= re_d;
            out_im    <= im_d;
            out_idx   <= idx_d;
            out_last  <= last_d;
            in_ready  <= ready_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        wcnt_d  = wcnt;
        scnt_d  = scnt;
        sel_d   = fft_sel;
        valid_d = out_valid;
        re_d    = out_re;
        im_d    = out_im;
        idx_d   = out_idx;
        last_d  = out_last;
        we      = 1'b0;
        unique case (state)
            LOAD: begin
                if (in_valid && in_ready) begin
                    we    = 1'b1;
                    cnt_d = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state_d = WAIT;
                        wcnt_d  = WCNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (wcnt == 4'd0) begin
                    state_d = SEL;
                    sel_d   = '0;
                    scnt_d  = SCNT_INIT;
                end else begin
                    wcnt_d = wcnt - 4'd1;
                end
            end
            SEL: begin
                if (scnt == 2'd0) begin
                    re_d    = fft_yr;
                    im_d    = fft_yi;
                    idx_d   = fft_sel;
                    last_d  = (fft_sel == 3'd7);
                    valid_d = 1'b1;
                    state_d = DRAIN;
                end else begin
                    scnt_d = scnt - 2'd1;
                end
            end
            DRAIN: begin
                // out_valid is always high here, so out_ready alone completes the handshake
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (fft_sel == 3'd7) begin
                        state_d = LOAD;
                    end else begin
                        sel_d   = fft_sel + 3'd1;
                        scnt_d  = SCNT_INIT;
                        state_d = SEL;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
        ready_d = (state_d == LOAD);
    end

    assign busy = !((state == LOAD) && (cnt == 3'd0));

endmodule

// File: tb/tb_dit_frame_ctrl.sv
// Self-checking bench for dit_frame_ctrl with a floating-point DFT standing in for the core.
// Second instance with CORE_LAT=4 checks the wait length scales with the parameter.
module tb_dit_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready;
    logic [2:0]  in_re, in_im;
    logic [23:0] fft_xr, fft_xi;
    logic [2:0]  fft_sel;
    logic [7:0]  fft_yr, fft_yi;
    logic        out_valid, out_ready;
    logic [7:0]  out_re, out_im;
    logic [2:0]  out_idx;
    logic        out_last, busy;

    logic        b_in_valid, b_in_ready;
    logic [2:0]  b_in_re, b_in_im;
    logic [23:0] b_fft_xr, b_fft_xi;
    logic [2:0]  b_fft_sel;
    logic [7:0]  b_fft_yr, b_fft_yi;
    logic        b_out_valid, b_out_ready;
    logic [7:0]  b_out_re, b_out_im;
    logic [2:0]  b_out_idx;
    logic        b_out_last, b_busy;

    dit_frame_ctrl #(.CORE_LAT(2), .SEL_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im),
        .fft_xr(fft_xr), .fft_xi(fft_xi), .fft_sel(fft_sel),
        .fft_yr(fft_yr), .fft_yi(fft_yi),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    dit_frame_ctrl #(.CORE_LAT(4), .SEL_LAT(1)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_re(b_in_re), .in_im(b_in_im),
        .fft_xr(b_fft_xr), .fft_xi(b_fft_xi), .fft_sel(b_fft_sel),
        .fft_yr(b_fft_yr), .fft_yi(b_fft_yi),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_re(b_out_re), .out_im(b_out_im),
        .out_idx(b_out_idx), .out_last(b_out_last), .busy(b_busy)
    );

    typedef logic [7:0][2:0] frame_t;
    typedef logic [7:0][7:0] bins_t;

    int br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int tests = 0;
    int fails = 0;

    function automatic logic [15:0] dft(input frame_t xr, input frame_t xi, input int k);
        real sr, si, a;
        int ir, ii;
        sr = 0.0;
        si = 0.0;
        for (int n = 0; n < 8; n++) begin
            a  = -2.0 * 3.14159265358979 * real'(k * n) / 8.0;
            sr = sr + real'(xr[n]) * $cos(a) - real'(xi[n]) * $sin(a);
            si = si + real'(xr[n]) * $sin(a) + real'(xi[n]) * $cos(a);
        end
        ir = $rtoi($floor(sr + 0.5));
        ii = $rtoi($floor(si + 0.5));
        return {ir[7:0], ii[7:0]};
    endfunction

    // Recover arrival order from the slot layout the core is given.
    function automatic frame_t arrival(input logic [23:0] x);
        frame_t r;
        for (int n = 0; n < 8; n++) begin
`ifdef DIT_FRAME_CTRL_BITREV_LOAD_EN
            r[n] = x[br[n]*3 +: 3];
`else
            r[n] = x[n*3 +: 3];
`endif
        end
        return r;
    endfunction

    always @(posedge clk) begin
        {fft_yr, fft_yi}     <= dft(arrival(fft_xr), arrival(fft_xi), int'(fft_sel));
        {b_fft_yr, b_fft_yi} <= dft(arrival(b_fft_xr), arrival(b_fft_xi), int'(b_fft_sel));
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic send_frame(input frame_t re, input frame_t im, input bit gapped,
                              output int lat);
        int n = 0;
        int guard = 0;
        bit ph = 1'b0;
        while (n < 8 && guard < 200) begin
            @(negedge clk);
            guard++;
            ph = ~ph;
            if (gapped && ph) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_re = re[n];
                in_im = im[n];
                if (in_ready) n++;
            end
        end
        if (n < 8) chk("send_timeout", 32'(n), 32'd8);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        chk("ready_low_after_8th", in_ready, 0);
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
            if (!out_valid) chk("ready_low_wait", in_ready, 0);
        end
    endtask

    task automatic collect(input bins_t er, input bins_t ei, input int stall_bin,
                           input int stall_len, input int stop_at);
        for (int b = 0; b < 8; b++) begin
            int g = 0;
            int sl;
            logic [21:0] snap;
            while (!out_valid && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (!out_valid) begin
                chk("result_timeout", 0, 1);
                return;
            end
            if (b == stop_at) begin
                out_ready = 1'b0;
                return;
            end
            sl = (b == stall_bin) ? stall_len :
                 (stall_bin == 8) ? int'($urandom_range(0, 3)) : 0;
            if (sl > 0) begin
                out_ready = 1'b0;
                snap = {out_re, out_im, out_idx, fft_sel};
                repeat (sl) begin
                    @(negedge clk);
                    chk("stall_hold", {out_valid, out_re, out_im, out_idx, fft_sel},
                        {1'b1, snap});
                end
                out_ready = 1'b1;
            end
            chk("idx", out_idx, b);
            chk("re", out_re, er[b]);
            chk("im", out_im, ei[b]);
            chk("last", out_last, b == 7);
            chk("ready_low_drain", in_ready, 0);
            @(negedge clk);
            chk("valid_drop", out_valid, 0);
            if (b == 7) begin
                chk("ready_back", in_ready, 1);
                chk("busy_idle", busy, 0);
            end
        end
    endtask

    typedef struct {
        frame_t re;
        frame_t im;
        bins_t  er;
        bins_t  ei;
        bit     gapped;
        int     stall_bin;
    } vec_t;

    vec_t tbl [3];

    initial begin
        int lat;
        frame_t fr, fi;
        bins_t er, ei;
        logic [15:0] d;

        for (int v = 0; v < 3; v++) begin
            tbl[v].im = '0;
            tbl[v].ei = '0;
            tbl[v].er = '0;
            tbl[v].stall_bin = -1;
            tbl[v].gapped = 1'b0;
        end
        for (int n = 0; n < 8; n++) begin
            tbl[0].re[n] = (n % 2 == 0) ? 3'd1 : 3'd0;
            tbl[1].re[n] = (n == 0) ? 3'd1 : 3'd0;
            tbl[1].er[n] = 8'd1;
            tbl[2].re[n] = (n % 2 == 0) ? 3'd1 : 3'd0;
        end
        tbl[0].er[0] = 8'd4;
        tbl[0].er[4] = 8'd4;
        tbl[1].stall_bin = 3;
        tbl[2].er[0] = 8'd4;
        tbl[2].er[4] = 8'd4;
        tbl[2].gapped = 1'b1;

        rst = 1'b0;
        in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_re = '0; b_in_im = '0; b_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel", fft_sel, 0);
        chk("rst_frame", fft_xr, 0);
        chk("rst_outs", {out_re, out_im, out_idx, out_last}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);

        for (int v = 0; v < 3; v++) begin
            send_frame(tbl[v].re, tbl[v].im, tbl[v].gapped, lat);
            chk("latency_cl2", 32'(lat), 32'd4);
            collect(tbl[v].er, tbl[v].ei, tbl[v].stall_bin, 5, 9);
        end

        for (int n = 0; n < 8; n++) fr[n] = 3'(n);
        fi = '0;
        send_frame(fr, fi, 1'b0, lat);
        for (int n = 0; n < 8; n++) begin
`ifdef DIT_FRAME_CTRL_BITREV_LOAD_EN
            chk("slot", 32'(fft_xr[br[n]*3 +: 3]), 32'(n));
`else
            chk("slot", 32'(fft_xr[n*3 +: 3]), 32'(n));
`endif
            d = dft(fr, fi, n);
            er[n] = d[15:8];
            ei[n] = d[7:0];
        end
        collect(er, ei, -1, 0, 9);

        send_frame(tbl[1].re, tbl[1].im, 1'b0, lat);
        collect(tbl[1].er, tbl[1].ei, -1, 0, 5);
        chk("pre_rst_idx", out_idx, 5);
        rst = 1'b0;
        #1;
        chk("async_valid_drop", out_valid, 0);
        chk("async_ready", in_ready, 0);
        chk("async_busy", busy, 0);
        chk("async_frame", fft_xr, 0);
        #2;
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("ready_after_midrst", in_ready, 1);
        fr = '0;
        fr[0] = 3'd4;
        fr[4] = 3'd4;
        er = '0;
        for (int n = 0; n < 8; n += 2) er[n] = 8'd8;
        send_frame(fr, '0, 1'b0, lat);
        collect(er, '0, -1, 0, 9);

        for (int f = 0; f < 20; f++) begin
            for (int n = 0; n < 8; n++) begin
                fr[n] = 3'($urandom_range(0, 7));
                fi[n] = 3'($urandom_range(0, 7));
            end
            for (int n = 0; n < 8; n++) begin
                d = dft(fr, fi, n);
                er[n] = d[15:8];
                ei[n] = d[7:0];
            end
            send_frame(fr, fi, 1'($urandom_range(0, 1)), lat);
            chk("latency_rand", 32'(lat), 32'd4);
            collect(er, ei, 8, 0, 9);
        end

        begin
            int n = 0;
            int guard = 0;
            int got = 0;
            bit ph = 1'b0;
            while (n < 8 && guard < 200) begin
                @(negedge clk);
                guard++;
                ph = ~ph;
                if (ph) begin
                    b_in_valid = 1'b0;
                end else begin
                    b_in_valid = 1'b1;
                    b_in_re = (n == 0) ? 3'd1 : 3'd0;
                    b_in_im = '0;
                    if (b_in_ready) n++;
                end
            end
            chk("b_accepts", 32'(n), 32'd8);
            @(negedge clk);
            b_in_valid = 1'b0;
            lat = 0;
            while (!b_out_valid && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            chk("latency_cl4", 32'(lat), 32'd6);
            guard = 0;
            while (got < 8 && guard < 200) begin
                if (b_out_valid) begin
                    chk("b_idx", b_out_idx, got);
                    chk("b_bin", {b_out_re, b_out_im}, {8'd1, 8'd0});
                    got++;
                end
                @(negedge clk);
                guard++;
            end
            chk("b_bins", 32'(got), 32'd8);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
